// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter. It drives open-drain
//               output enables and optionally resends the byte after an error
//               when the PS2_TX_RESEND_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int c_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_timer;
    logic [3:0]           r_bit;
    logic [9:0]           r_shift;
    logic                 r_dat_oe;
    logic                 r_clk_s1, r_clk_s2, r_clk_prev;
    logic                 r_dat_s1, r_dat_s2;
    logic                 w_fe;
    logic                 w_fail;
    logic                 w_can_retry;
    logic [9:0]           w_reload_frame;

    assign w_fe = r_clk_prev & ~r_clk_s2;

`ifdef PS2_TX_RESEND_EN
    localparam int c_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [c_RTY_W-1:0] r_retry;
    logic [7:0]         r_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry <= '0;
            r_byte  <= 8'h00;
        end else if (r_state == S_IDLE && tx_valid) begin
            r_retry <= '0;
            r_byte  <= tx_data;
        end else if (w_fail && w_can_retry) begin
            r_retry <= r_retry + 1'b1;
        end
    end

    assign w_can_retry    = (r_retry < c_RTY_W'(MAX_RETRY));
    assign w_reload_frame = {1'b1, ~^r_byte, r_byte};
`else
    assign w_can_retry    = 1'b0;
    assign w_reload_frame = r_shift;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        case (r_state)
            S_IDLE:      if (tx_valid) w_state_nxt = S_INHIBIT;
            S_INHIBIT:   if (r_timer == c_INH_LAST) w_state_nxt = S_START;
            S_START:     w_state_nxt = S_SEND;
            S_SEND: begin
                if (w_fe) begin
                    if (r_bit == 4'd9) w_state_nxt = S_ACK;
                end else if (r_timer == c_TMO_LAST) begin
                    w_fail = 1'b1;
                end
            end
            S_ACK: begin
                if (w_fe) begin
                    if (r_dat_s2) w_fail = 1'b1;
                    else          w_state_nxt = S_WAIT_IDLE;
                end else if (r_timer == c_TMO_LAST) begin
                    w_fail = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_s2 && r_dat_s2) begin
                    tx_done     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == c_TMO_LAST) begin
                    w_fail = 1'b1;
                end
            end
            default:     w_state_nxt = S_IDLE;
        endcase
        if (w_fail) begin
            if (w_can_retry) begin
                w_state_nxt = S_INHIBIT;
            end else begin
                w_state_nxt = S_IDLE;
                tx_err      = 1'b1;
            end
        end
        tx_ready   = (r_state == S_IDLE);
        tx_busy    = (r_state != S_IDLE);
        ps2_clk_oe = (r_state == S_INHIBIT) || (r_state == S_START);
        // A failing cycle already lets go of the data line.
        ps2_dat_oe = (r_state == S_START) || ((r_state == S_SEND) && r_dat_oe && !w_fail);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit      <= 4'd0;
            r_shift    <= 10'h3FF;
            r_dat_oe   <= 1'b0;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_dat_in;
            r_dat_s2   <= r_dat_s1;
            r_state    <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_shift <= {1'b1, ~^tx_data, tx_data};
                        r_bit   <= 4'd0;
                        r_timer <= '0;
                    end
                end
                S_INHIBIT: r_timer <= r_timer + 1'b1;
                S_START: begin
                    r_timer  <= '0;
                    r_dat_oe <= 1'b1;
                end
                S_SEND: begin
                    if (w_fe) begin
                        r_timer  <= '0;
                        r_dat_oe <= ~r_shift[0];
                        r_shift  <= {1'b1, r_shift[9:1]};
                        r_bit    <= r_bit + 1'b1;
                    end else begin
                        r_timer  <= r_timer + 1'b1;
                    end
                end
                S_ACK, S_WAIT_IDLE: r_timer <= w_fe ? '0 : r_timer + 1'b1;
                default: ;
            endcase
            if (w_fail && w_can_retry) begin
                r_shift <= w_reload_frame;
                r_bit   <= 4'd0;
                r_timer <= '0;
            end
        end
    end

endmodule
`default_nettype wire
